// File: rtl/nibble_sequencer_if.sv
`timescale 1ns/1ps
// Purpose : groups the program-ROM and datapath-control signals of one nibble processor.
// Latency : none; this is only a bundle of wires.
// Backpressure: none; the sequencer is free-running and every signal here is point-to-point.
// Ports   : master = sequencer side (drives rom_addr and the control outputs, reads rom_data/c/z);
//           slave  = ROM + datapath side (drives rom_data/c/z, reads everything else).
interface nibble_sequencer_if;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        c;
    logic        z;
    logic [2:0]  sel;
    logic        accu_en;
    logic        bus1_en;
    logic        bus2_en;
    logic [3:0]  operand;
    logic        out_strobe;
    logic        c_flag;
    logic        z_flag;
    logic        halted;

    modport master (
        output rom_addr, sel, accu_en, bus1_en, bus2_en, operand,
               out_strobe, c_flag, z_flag, halted,
        input  rom_data, c, z
    );

    modport slave (
        input  rom_addr, sel, accu_en, bus1_en, bus2_en, operand,
               out_strobe, c_flag, z_flag, halted,
        output rom_data, c, z
    );
endinterface

// File: rtl/nibble_sequencer.sv
`timescale 1ns/1ps
// Purpose : fetch/decode control unit for the 4-bit accumulator datapath, fed by an async-read ROM.
// Latency : 2 cycles per instruction (FETCH, EXEC), 3 for jumps (FETCH, EXEC, JADDR); accumulator
//           result visible the cycle after EXEC.  Backpressure: none, free-running until HALT.
// Ports   : clk, reset (async, active-high); bus (nibble_sequencer_if.master):
//           rom_addr/rom_data program ROM; c/z ALU flags in; sel, accu_en, bus1_en, bus2_en,
//           operand, out_strobe datapath controls; c_flag/z_flag registered flags; halted status.
// Option  : define NIBBLE_SEQ_COND_JUMP_EN to make opcodes 0x7-0xA two-byte conditional jumps
//           (JC, JNC, JZ, JNZ); without it they decode as one-byte NOPs.
module nibble_sequencer #(
    parameter logic [11:0] RESET_VECTOR = 12'h000
) (
    input  logic               clk,
    input  logic               reset,
    nibble_sequencer_if.master bus
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LIT  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_NAND = 4'h4;
    localparam logic [3:0] OP_OUT  = 4'h5;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_JC   = 4'h7;
    localparam logic [3:0] OP_JNC  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JNZ  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] SEL_PASSA = 3'd0;
    localparam logic [2:0] SEL_SUB   = 3'd1;
    localparam logic [2:0] SEL_PASSB = 3'd2;
    localparam logic [2:0] SEL_ADD   = 3'd3;
    localparam logic [2:0] SEL_NAND  = 3'd4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_JADDR = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] pc, pc_nxt;
    logic [7:0]  ir, ir_nxt;
    logic        c_q, z_q, c_nxt, z_nxt;

    logic [3:0]  opcode;
    logic        is_jump;
    logic        jump_taken;

    logic [2:0]  sel;
    logic        accu_en;
    logic        bus1_en;
    logic        bus2_en;
    logic [3:0]  operand;
    logic        out_strobe;
    logic        flag_upd;

    assign opcode = ir[7:4];

    // Jump classification.  Conditions look only at the registered flags, which cannot change
    // while a jump is in flight because jumps never request a flag update.
    always_comb begin
        is_jump    = 1'b0;
        jump_taken = 1'b0;
        case (opcode)
`ifdef NIBBLE_SEQ_COND_JUMP_EN
            OP_JC:  begin is_jump = 1'b1; jump_taken = c_q;  end
            OP_JNC: begin is_jump = 1'b1; jump_taken = !c_q; end
            OP_JZ:  begin is_jump = 1'b1; jump_taken = z_q;  end
            OP_JNZ: begin is_jump = 1'b1; jump_taken = !z_q; end
`else
            OP_JC, OP_JNC, OP_JZ, OP_JNZ: begin
                is_jump    = 1'b0;
                jump_taken = 1'b0;
            end
`endif
            OP_JMP: begin is_jump = 1'b1; jump_taken = 1'b1; end
            default: begin
                is_jump    = 1'b0;
                jump_taken = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_VECTOR;
            ir    <= 8'h00;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            c_q   <= c_nxt;
            z_q   <= z_nxt;
        end
    end

    // Next state and control outputs.  All datapath controls are combinational from state+ir
    // so an asynchronous reset removes them in the same cycle.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_nxt     = ir;
        c_nxt      = c_q;
        z_nxt      = z_q;
        sel        = SEL_PASSA;
        accu_en    = 1'b0;
        bus1_en    = 1'b0;
        bus2_en    = 1'b0;
        operand    = 4'h0;
        out_strobe = 1'b0;
        flag_upd   = 1'b0;

        case (state)
            S_FETCH: begin
                ir_nxt    = bus.rom_data;
                state_nxt = S_EXEC;
                // A HALT byte does not advance pc, so rom_addr stays parked on the HALT
                // instruction for as long as the core is halted.
                if (bus.rom_data[7:4] != OP_HALT) begin
                    pc_nxt = pc + 12'd1;
                end
            end

            S_EXEC: begin
                operand   = ir[3:0];
                state_nxt = S_FETCH;
                case (opcode)
                    OP_LIT: begin
                        sel     = SEL_PASSB;
                        bus1_en = 1'b1;
                        accu_en = 1'b1;
                    end
                    OP_ADD: begin
                        sel      = SEL_ADD;
                        bus1_en  = 1'b1;
                        accu_en  = 1'b1;
                        flag_upd = 1'b1;
                    end
                    OP_SUB: begin
                        sel      = SEL_SUB;
                        bus1_en  = 1'b1;
                        accu_en  = 1'b1;
                        flag_upd = 1'b1;
                    end
                    OP_NAND: begin
                        sel      = SEL_NAND;
                        bus1_en  = 1'b1;
                        accu_en  = 1'b1;
                        flag_upd = 1'b1;
                    end
                    OP_OUT: begin
                        sel        = SEL_PASSA;
                        bus2_en    = 1'b1;
                        out_strobe = 1'b1;
                    end
                    OP_CMP: begin
                        // Subtract for flags only; the accumulator keeps its value.
                        sel      = SEL_SUB;
                        bus1_en  = 1'b1;
                        flag_upd = 1'b1;
                    end
                    OP_HALT: begin
                        state_nxt = S_HALT;
                    end
                    default: begin
                        // NOP, reserved opcodes and the first cycle of a jump: no enables.
                        if (is_jump) begin
                            state_nxt = S_JADDR;
                        end
                    end
                endcase
                if (flag_upd) begin
                    c_nxt = bus.c;
                    z_nxt = bus.z;
                end
            end

            S_JADDR: begin
                // rom_data is the low address byte sitting at pc; the high nibble came with ir.
                state_nxt = S_FETCH;
                if (jump_taken) begin
                    pc_nxt = {ir[3:0], bus.rom_data};
                end else begin
                    pc_nxt = pc + 12'd1;
                end
            end

            S_HALT: begin
                state_nxt = S_HALT;
            end

            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign bus.rom_addr   = pc;
    assign bus.sel        = sel;
    assign bus.accu_en    = accu_en;
    assign bus.bus1_en    = bus1_en;
    assign bus.bus2_en    = bus2_en;
    assign bus.operand    = operand;
    assign bus.out_strobe = out_strobe;
    assign bus.c_flag     = c_q;
    assign bus.z_flag     = z_q;
    assign bus.halted     = (state == S_HALT);

endmodule

// File: tb/tb_nibble_sequencer.sv
`timescale 1ns/1ps
// Bench for nibble_sequencer: a behavioural ROM and accumulator datapath surround the DUT, and an
// instruction-level interpreter predicts the per-cycle control outputs for each program.
module tb_nibble_sequencer;

`ifdef NIBBLE_SEQ_COND_JUMP_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    nibble_sequencer_if bus_if ();

    nibble_sequencer #(.RESET_VECTOR(12'h000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Program ROM, asynchronous read.
    logic [7:0] rom [4096];
    assign bus_if.rom_data = rom[bus_if.rom_addr];

    // Accumulator datapath fixture driven by the DUT controls.
    logic [3:0] fx_accu, fx_b, fx_res;
    logic       fx_c;
    always_comb begin
        fx_b   = bus_if.bus1_en ? bus_if.operand : 4'h0;
        fx_c   = 1'b0;
        fx_res = fx_accu;
        case (bus_if.sel)
            3'd0: fx_res = fx_accu;
            3'd1: {fx_c, fx_res} = {1'b0, fx_accu} - {1'b0, fx_b};
            3'd2: fx_res = fx_b;
            3'd3: {fx_c, fx_res} = {1'b0, fx_accu} + {1'b0, fx_b};
            3'd4: fx_res = ~(fx_accu & fx_b);
            default: fx_res = fx_accu;
        endcase
    end
    assign bus_if.c = fx_c;
    assign bus_if.z = (fx_res == 4'h0);

    always @(posedge clk or posedge reset) begin
        if (reset)               fx_accu <= 4'h0;
        else if (bus_if.accu_en) fx_accu <= fx_res;
    end

    // Expected output record for one clock cycle.
    typedef struct {
        logic [11:0] addr;
        logic [2:0]  sel;
        logic        accu_en, bus1_en, bus2_en, strobe;
        logic [3:0]  operand;
        logic [3:0]  out_val;
        logic        cf, zf, halted;
    } exp_t;

    exp_t q[$];

    // Interpreter state.
    logic [11:0] m_pc;
    logic [3:0]  m_accu;
    logic        m_cf, m_zf, m_halted;

    int   nvec, nfail;
    logic chk_en;
    logic [3:0] last_out;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t idle_rec(input logic [11:0] a);
        exp_t r;
        r.addr = a; r.sel = 3'd0; r.accu_en = 1'b0; r.bus1_en = 1'b0; r.bus2_en = 1'b0;
        r.strobe = 1'b0; r.operand = 4'h0; r.out_val = 4'h0;
        r.cf = m_cf; r.zf = m_zf; r.halted = m_halted;
        return r;
    endfunction

    task automatic model_reset();
        m_pc = 12'h000; m_accu = 4'h0; m_cf = 1'b0; m_zf = 1'b0; m_halted = 1'b0;
        q.delete();
    endtask

    // Run the program instruction by instruction, emitting one record per clock cycle.
    task automatic gen(input int limit);
        exp_t       r;
        logic [7:0] ins;
        logic [3:0] op, n;
        logic [4:0] w;
        bit         jmp, taken;
        while (q.size() < limit) begin
            if (m_halted) begin
                q.push_back(idle_rec(m_pc));
                continue;
            end
            ins = rom[m_pc]; op = ins[7:4]; n = ins[3:0];
            q.push_back(idle_rec(m_pc));                 // fetch cycle
            if (op == 4'hF) begin
                r = idle_rec(m_pc); r.operand = n;
                q.push_back(r);
                m_halted = 1'b1;
                continue;
            end
            m_pc = m_pc + 12'd1;
            r = idle_rec(m_pc); r.operand = n;
            case (op)
                4'h1: begin r.sel = 3'd2; r.bus1_en = 1; r.accu_en = 1; m_accu = n; end
                4'h2: begin
                    r.sel = 3'd3; r.bus1_en = 1; r.accu_en = 1;
                    w = {1'b0, m_accu} + {1'b0, n};
                    m_accu = w[3:0]; m_cf = w[4]; m_zf = (w[3:0] == 4'h0);
                end
                4'h3: begin
                    r.sel = 3'd1; r.bus1_en = 1; r.accu_en = 1;
                    m_cf = (m_accu < n); m_accu = m_accu - n; m_zf = (m_accu == 4'h0);
                end
                4'h4: begin
                    r.sel = 3'd4; r.bus1_en = 1; r.accu_en = 1;
                    m_accu = ~(m_accu & n); m_cf = 1'b0; m_zf = (m_accu == 4'h0);
                end
                4'h5: begin r.bus2_en = 1; r.strobe = 1; r.out_val = m_accu; end
                4'h6: begin
                    r.sel = 3'd1; r.bus1_en = 1;
                    m_cf = (m_accu < n); m_zf = (m_accu == n);
                end
                default: ;
            endcase
            q.push_back(r);
            jmp = (op == 4'hB) || (COND && op >= 4'h7 && op <= 4'hA);
            if (jmp) begin
                q.push_back(idle_rec(m_pc));             // second-byte cycle
                case (op)
                    4'h7:    taken = m_cf;
                    4'h8:    taken = !m_cf;
                    4'h9:    taken = m_zf;
                    4'hA:    taken = !m_zf;
                    default: taken = 1'b1;
                endcase
                m_pc = taken ? {n, rom[m_pc]} : m_pc + 12'd1;
            end
        end
    endtask

    // Compare process: one expected record per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (bus_if.out_strobe) last_out = fx_res;
            if (q.size() == 0) begin
                chk("model_underrun", 16'd1, 16'd0);
            end else begin
                e = q.pop_front();
                chk("rom_addr",   16'(bus_if.rom_addr),   16'(e.addr));
                chk("sel",        16'(bus_if.sel),        16'(e.sel));
                chk("accu_en",    16'(bus_if.accu_en),    16'(e.accu_en));
                chk("bus1_en",    16'(bus_if.bus1_en),    16'(e.bus1_en));
                chk("bus2_en",    16'(bus_if.bus2_en),    16'(e.bus2_en));
                chk("out_strobe", 16'(bus_if.out_strobe), 16'(e.strobe));
                chk("operand",    16'(bus_if.operand),    16'(e.operand));
                chk("c_flag",     16'(bus_if.c_flag),     16'(e.cf));
                chk("z_flag",     16'(bus_if.z_flag),     16'(e.zf));
                chk("halted",     16'(bus_if.halted),     16'(e.halted));
                if (e.bus2_en) chk("out_bus", 16'(fx_res), 16'(e.out_val));
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_addr"},    16'(bus_if.rom_addr),   16'h000);
        chk({tag, "_sel"},     16'(bus_if.sel),        16'h0);
        chk({tag, "_accu_en"}, 16'(bus_if.accu_en),    16'h0);
        chk({tag, "_bus1"},    16'(bus_if.bus1_en),    16'h0);
        chk({tag, "_bus2"},    16'(bus_if.bus2_en),    16'h0);
        chk({tag, "_strobe"},  16'(bus_if.out_strobe), 16'h0);
        chk({tag, "_operand"}, 16'(bus_if.operand),    16'h0);
        chk({tag, "_flags"},   16'({bus_if.c_flag, bus_if.z_flag}), 16'h0);
        chk({tag, "_halted"},  16'(bus_if.halted),     16'h0);
    endtask

    // Release reset, follow the model for the whole program (or only abort_at cycles, then
    // assert reset in the middle of a cycle).  Reset must be high on entry.
    task automatic run_prog(input int limit, input int abort_at);
        int n;
        model_reset();
        gen(limit);
        n = q.size();
        if (abort_at > 0 && abort_at < n) n = abort_at;
        @(posedge clk); #1 reset = 1'b0; chk_en = 1'b1;
        repeat (n) @(posedge clk);
        #1 chk_en = 1'b0;
        if (abort_at > 0) begin
            #1 reset = 1'b1;
            #1 chk_reset_state("midrst");
            q.delete();
        end else begin
            chk("model_drained", 16'(q.size()), 16'd0);
        end
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1 chk_reset_state("async");
        @(negedge clk) chk_reset_state("held");
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
    endtask

    task automatic rand_rom();
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 8'($urandom);
            // Thin out HALTs so random programs run for a while.
            if (rom[i][7:4] == 4'hF && $urandom_range(3, 0) != 0)
                rom[i][7:4] = 4'($urandom_range(14, 0));
        end
    endtask

    initial begin
        reset = 1'b1; chk_en = 1'b0; nvec = 0; nfail = 0; last_out = 4'h0;
        fill_rom();
        repeat (2) @(negedge clk);
        chk_reset_state("por");

        // LIT 5, ADD 7, OUT, HALT; first abandoned in its first EXEC (accu_en high).
        rom[0] = 8'h15; rom[1] = 8'h27; rom[2] = 8'h50; rom[3] = 8'hF0;
        run_prog(40, 1);
        run_prog(40, 0);
        chk("p1_accu",   16'(fx_accu),         16'd12);
        chk("p1_model",  16'(m_accu),          16'd12);
        chk("p1_out",    16'(last_out),        16'd12);
        chk("p1_flags",  16'({bus_if.c_flag, bus_if.z_flag}), 16'b00);
        chk("p1_halted", 16'(bus_if.halted),   16'd1);
        chk("p1_addr",   16'(bus_if.rom_addr), 16'h003);
        do_reset();

        // LIT F, ADD 1 -> 0 with carry and zero; OUT drives 0.
        fill_rom();
        rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h50;
        run_prog(40, 0);
        chk("p2_accu",   16'(fx_accu),  16'd0);
        chk("p2_out",    16'(last_out), 16'd0);
        chk("p2_flags",  16'({bus_if.c_flag, bus_if.z_flag}), 16'b11);
        chk("p2_addr",   16'(bus_if.rom_addr), 16'h003);
        do_reset();

        // LIT 3, CMP 3, JZ 010 (or NOP + LIT 0 without conditional jumps), HALT.
        fill_rom();
        rom[0] = 8'h13; rom[1] = 8'h63; rom[2] = 8'h90; rom[3] = 8'h10; rom[4] = 8'hF0;
        rom[12'h00F] = 8'h1F;
        run_prog(40, 0);
        chk("p3_accu",   16'(fx_accu),  COND ? 16'd3 : 16'd0);
        chk("p3_zflag",  16'(bus_if.z_flag), 16'd1);
        chk("p3_halted", 16'(bus_if.halted), 16'd1);
        chk("p3_addr",   16'(bus_if.rom_addr), COND ? 16'h010 : 16'h004);
        do_reset();

        // JMP FFE; at FFE a JMP 000 whose second byte sits at FFF.
        fill_rom();
        rom[0] = 8'hBF; rom[1] = 8'hFE; rom[12'hFFE] = 8'hB0; rom[12'hFFF] = 8'h00;
        model_reset(); gen(20);
        chk("p4_model_b1", 16'(q[5].addr), 16'hFFF);
        chk("p4_model_wrap", 16'(q[6].addr), 16'h000);
        run_prog(40, 0);
        do_reset();

        // JMP FFF; plain NOP at FFF, pc wraps to 000.
        fill_rom();
        rom[0] = 8'hBF; rom[1] = 8'hFF; rom[12'hFFF] = 8'h00;
        model_reset(); gen(20);
        chk("p5_model_wrap", 16'(q[4].addr), 16'h000);
        run_prog(40, 0);
        do_reset();

        // Random programs, each also cut short once by a reset at a random point.
        for (int t = 0; t < 6; t++) begin
            rand_rom();
            run_prog(400, int'($urandom_range(60, 2)));
            run_prog(400, 0);
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
